// File: rtl/xain_pkg.sv
`default_nettype none
// xain_pkg: shared ROM region descriptors and read-side types for the xain gfx path.
package xain_pkg;

  typedef struct packed {
    logic [24:0] base_addr;
    logic        reorder_16;
    logic        bram_cs;
  } region_t;

  localparam region_t REGION_ROM_BACK1 = '{base_addr: 25'h0040000, reorder_16: 1'b0, bram_cs: 1'b0};
  localparam region_t REGION_ROM_BACK2 = '{base_addr: 25'h0080000, reorder_16: 1'b0, bram_cs: 1'b0};
  localparam region_t REGION_ROM_OBJ   = '{base_addr: 25'h00C0000, reorder_16: 1'b0, bram_cs: 1'b0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  localparam int NUM_RD_CLIENTS = 3;
  localparam int RD_OFS_W       = 18;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter: N-way round-robin arbiter; priority rotates to the client after
// the last granted one whenever i_adv is strobed.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_adv,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] r_ptr;
  int            w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(r_ptr) + k) % N;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IW'(w_j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_adv && o_any) begin
      r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rom_region_reader.sv
`default_nettype none
// rom_region_reader: serves per-client gfx ROM fetches from SDRAM load regions,
// round-robin onto one read port, with a one-word hit register per client.
module rom_region_reader
  import xain_pkg::*;
#(
  parameter int NUM_CLIENTS = NUM_RD_CLIENTS,
  parameter int OFS_W       = RD_OFS_W,
  parameter region_t [NUM_CLIENTS-1:0] REGIONS = {REGION_ROM_OBJ, REGION_ROM_BACK2, REGION_ROM_BACK1}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_inv,
  input  logic [NUM_CLIENTS-1:0]    i_clt_req,
  input  logic [NUM_CLIENTS*OFS_W-1:0] i_clt_ofs,
  output logic [NUM_CLIENTS-1:0]    o_clt_ack,
  output logic [NUM_CLIENTS*16-1:0] o_clt_data,
  output logic                      o_sdr_req,
  output logic [24:0]               o_sdr_addr,
  input  logic                      i_sdr_ack,
  input  logic [15:0]               i_sdr_rdata,
  input  logic                      i_sdr_rvalid
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  rd_state_t r_state, w_state_nxt;

  logic [IW-1:0]           r_gnt;
  logic [NUM_CLIENTS-1:0]  r_gnt_oh;
  logic [OFS_W-2:0]        r_word;
  logic [24:0]             r_sdr_addr;
  logic [15:0]             r_rdata;
  logic                    r_inv_seen;
  logic [NUM_CLIENTS-1:0]  r_ack;
  logic [NUM_CLIENTS*16-1:0] r_clt_data;
  logic [NUM_CLIENTS-1:0]  r_hit_vld;
  logic [OFS_W-2:0]        r_hit_word [NUM_CLIENTS];
  logic [15:0]             r_hit_data [NUM_CLIENTS];

  logic [OFS_W-2:0]        w_word [NUM_CLIENTS];
  logic [24:0]             w_addr [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0]  w_reorder;
  logic [NUM_CLIENTS-1:0]  w_hit, w_miss, w_gnt_oh;
  logic [IW-1:0]           w_gnt_idx;
  logic                    w_gnt_any, w_grant, w_done, w_busy;

  assign w_busy  = (r_state != IDLE);
  assign w_grant = (r_state == IDLE) && w_gnt_any;
  assign w_done  = (r_state == DONE);

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_clt
    assign w_word[i]    = i_clt_ofs[i*OFS_W+1 +: OFS_W-1];
    assign w_addr[i]    = REGIONS[i].base_addr + 25'({w_word[i], 1'b0});
    assign w_reorder[i] = REGIONS[i].reorder_16;
    // An ack last cycle means the client has not yet seen it and dropped req.
    assign w_hit[i]  = i_clt_req[i] & r_hit_vld[i] & (w_word[i] == r_hit_word[i]) & ~r_ack[i];
    assign w_miss[i] = i_clt_req[i] & ~w_hit[i] & ~r_ack[i] & ~(w_busy & r_gnt_oh[i]);

    if (REGIONS[i].bram_cs != 1'b0) begin : g_bram_err
      $error("rom_region_reader: client %0d maps a BRAM region, not SDRAM-readable", i);
    end
  end

  rr_arbiter #(
    .N  (NUM_CLIENTS),
    .IW (IW)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (w_miss),
    .i_adv (w_grant),
    .o_gnt (w_gnt_oh),
    .o_idx (w_gnt_idx),
    .o_any (w_gnt_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_sdr_req   = 1'b0;
    case (r_state)
      IDLE:  if (w_gnt_any) w_state_nxt = ISSUE;
      ISSUE: begin
        o_sdr_req = 1'b1;
        if (i_sdr_ack) w_state_nxt = WAIT;
      end
      WAIT:  if (i_sdr_rvalid) w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt      <= '0;
      r_gnt_oh   <= '0;
      r_word     <= '0;
      r_sdr_addr <= '0;
      r_rdata    <= '0;
      r_inv_seen <= 1'b0;
      r_ack      <= '0;
      r_clt_data <= '0;
      r_hit_vld  <= '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        r_hit_word[i] <= '0;
        r_hit_data[i] <= '0;
      end
    end else begin
      if (w_grant) begin
        r_gnt      <= w_gnt_idx;
        r_gnt_oh   <= w_gnt_oh;
        r_word     <= w_word[w_gnt_idx];
        r_sdr_addr <= w_addr[w_gnt_idx];
      end
      if (r_state == WAIT && i_sdr_rvalid) begin
        r_rdata <= w_reorder[r_gnt] ? {i_sdr_rdata[7:0], i_sdr_rdata[15:8]} : i_sdr_rdata;
      end
      // Any inv between ISSUE and DONE makes the returning word unsafe to cache.
      if (r_state == IDLE) r_inv_seen <= 1'b0;
      else if (i_inv)      r_inv_seen <= 1'b1;

      r_ack <= w_hit | (w_done ? (r_gnt_oh & i_clt_req) : '0);
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (w_hit[i])
          r_clt_data[i*16 +: 16] <= r_hit_data[i];
        else if (w_done && r_gnt_oh[i] && i_clt_req[i])
          r_clt_data[i*16 +: 16] <= r_rdata;

        if (i_inv)
          r_hit_vld[i] <= 1'b0;
        else if (w_done && r_gnt_oh[i])
          r_hit_vld[i] <= ~r_inv_seen;

        if (w_done && r_gnt_oh[i]) begin
          r_hit_word[i] <= r_word;
          r_hit_data[i] <= r_rdata;
        end
      end
    end
  end

  assign o_clt_ack  = r_ack;
  assign o_clt_data = r_clt_data;
  assign o_sdr_addr = r_sdr_addr;

endmodule
`default_nettype wire

// File: tb/tb_rom_region_reader.sv
`default_nettype none
// tb_rom_region_reader: scoreboard bench with an SDRAM responder, directed
// scenarios and a randomized multi-client phase.
module tb_rom_region_reader;
  import xain_pkg::*;

  localparam region_t OBJ_SWAP = '{base_addr: 25'h00C0000, reorder_16: 1'b1, bram_cs: 1'b0};
  localparam logic [24:0] M_BASE [3] = '{25'h0040000, 25'h0080000, 25'h00C0000};
  localparam bit          M_SWAP [3] = '{1'b0, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inv;
  logic [2:0]  clt_req;
  logic [53:0] clt_ofs;
  logic [2:0]  clt_ack;
  logic [47:0] clt_data;
  logic        sdr_req;
  logic [24:0] sdr_addr;
  logic        sdr_ack;
  logic [15:0] sdr_rdata;
  logic        sdr_rvalid;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rd     = 0;
  int ack_lo = 0, ack_hi = 0, rv_lo = 0, rv_hi = 0;
  bit rv_hold = 1'b0;

  logic [15:0] mem [logic [24:0]];
  logic [15:0] sbq [3][$];
  logic [24:0] rd_log [$];
  bit          mh_vld  [3];
  logic [16:0] mh_word [3];

  rom_region_reader #(
    .NUM_CLIENTS (3),
    .OFS_W       (18),
    .REGIONS     ({OBJ_SWAP, REGION_ROM_BACK2, REGION_ROM_BACK1})
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_inv        (inv),
    .i_clt_req    (clt_req),
    .i_clt_ofs    (clt_ofs),
    .o_clt_ack    (clt_ack),
    .o_clt_data   (clt_data),
    .o_sdr_req    (sdr_req),
    .o_sdr_addr   (sdr_addr),
    .i_sdr_ack    (sdr_ack),
    .i_sdr_rdata  (sdr_rdata),
    .i_sdr_rvalid (sdr_rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [24:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'(a >> 1) ^ 16'hC3A5;
  endfunction

  function automatic logic [24:0] model_addr(input int i, input logic [17:0] ofs);
    return M_BASE[i] + {7'd0, ofs[17:1], 1'b0};
  endfunction

  function automatic logic [15:0] model_data(input int i, input logic [17:0] ofs);
    logic [15:0] d;
    d = mem_rd(model_addr(i, ofs));
    return M_SWAP[i] ? {d[7:0], d[15:8]} : d;
  endfunction

  function automatic logic [24:0] last_rd();
    if (rd_log.size() == 0) return 25'h1FFFFFF;
    return rd_log[rd_log.size()-1];
  endfunction

  // exp_lat > 0 demands that exact latency; 0 lets the hit model decide.
  task automatic do_req(input int i, input logic [17:0] ofs, input int exp_lat);
    int lat;
    bit got;
    bit hit;
    hit = mh_vld[i] && (mh_word[i] == ofs[17:1]);
    @(posedge clk); #1;
    sbq[i].push_back(model_data(i, ofs));
    clt_ofs[i*18 +: 18] = ofs;
    clt_req[i] = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 300) begin
      @(negedge clk);
      if (clt_ack[i]) got = 1'b1;
      else lat++;
    end
    chk($sformatf("req_ack_c%0d", i), got, 1'b1);
    if (!got) void'(sbq[i].pop_back());
    if (exp_lat > 0)  chk($sformatf("lat_c%0d", i), lat, exp_lat);
    else if (hit)     chk($sformatf("hit_lat_c%0d", i), lat, 1);
    else              chk($sformatf("miss_lat_c%0d", i), (lat >= 4), 1'b1);
    @(posedge clk); #1;
    clt_req[i] = 1'b0;
    mh_vld[i]  = 1'b1;
    mh_word[i] = ofs[17:1];
  endtask

  task automatic pulse_inv();
    @(posedge clk); #1;
    inv = 1'b1;
    for (int k = 0; k < 3; k++) mh_vld[k] = 1'b0;
    @(posedge clk); #1;
    inv = 1'b0;
  endtask

  task automatic client_loop(input int i);
    logic [17:0] tbl [4];
    tbl = '{18'h00010, 18'h00011, 18'h1F002, 18'h3FFFF};
    repeat (8) begin
      do_req(i, tbl[$urandom_range(3, 0)], 0);
      repeat ($urandom_range(2, 0)) @(posedge clk);
    end
  endtask

  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (clt_ack[k]) begin
          if (sbq[k].size() == 0) begin
            chk($sformatf("unexpected_ack_c%0d", k), 1'b1, 1'b0);
          end else begin
            e = sbq[k].pop_front();
            chk($sformatf("data_c%0d", k), clt_data[k*16 +: 16], e);
          end
        end
      end
    end
  end

  initial begin : sdram
    logic [24:0] a;
    bit ok;
    sdr_ack = 1'b0; sdr_rvalid = 1'b0; sdr_rdata = '0;
    forever begin
      @(negedge clk);
      if (sdr_req) begin
        ok = 1'b0;
        for (int k = 0; k < 3; k++)
          if (clt_req[k] && model_addr(k, clt_ofs[k*18 +: 18]) == sdr_addr) ok = 1'b1;
        chk("sdr_addr_legal", ok, 1'b1);
        repeat ($urandom_range(ack_hi, ack_lo)) @(negedge clk);
        a = sdr_addr;
        sdr_ack = 1'b1;
        @(negedge clk);
        sdr_ack = 1'b0;
        n_rd++;
        rd_log.push_back(a);
        repeat ($urandom_range(rv_hi, rv_lo)) @(negedge clk);
        while (rv_hold) @(negedge clk);
        sdr_rvalid = 1'b1;
        sdr_rdata  = mem_rd(a);
        @(negedge clk);
        sdr_rvalid = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0;
    int c;
    rst_n = 1'b0; inv = 1'b0; clt_req = '0; clt_ofs = '0;
    for (int k = 0; k < 3; k++) begin mh_vld[k] = 1'b0; mh_word[k] = '0; end
    mem[25'h0040124] = 16'hBEEF;
    mem[25'h00FFFFE] = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", clt_ack, 3'b000);
    chk("rst_data", clt_data[31:0], 32'h0);
    chk("rst_data2", clt_data[47:32], 16'h0);
    chk("rst_sdr_req", sdr_req, 1'b0);
    chk("rst_sdr_addr", sdr_addr, 25'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic miss with delayed controller accept.
    ack_lo = 2; ack_hi = 2;
    do_req(0, 18'h00124, 6);
    chk("t1_addr", last_rd(), 25'h0040124);
    ack_lo = 0; ack_hi = 0;

    // Same word hits without SDRAM; after inv it misses again.
    n0 = n_rd;
    do_req(0, 18'h00125, 1);
    chk("t2_hit_no_rd", n_rd, n0);
    pulse_inv();
    do_req(0, 18'h00125, 4);
    chk("t2_inv_rd", n_rd, n0 + 1);
    chk("t2_inv_addr", last_rd(), 25'h0040124);

    // Byte-swapped region at the top of its span.
    do_req(2, 18'h3FFFE, 4);
    chk("t3_addr", last_rd(), 25'h00FFFFE);
    chk("t3_swap", clt_data[47:32], 16'h3412);

    // Round-robin order with three simultaneous misses, then pointer wrap.
    rd_log.delete();
    fork
      do_req(0, 18'h00100, 0);
      do_req(1, 18'h00200, 0);
      do_req(2, 18'h00300, 0);
    join
    chk("rr_cnt", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      chk("rr_0", rd_log[0], 25'h0040100);
      chk("rr_1", rd_log[1], 25'h0080200);
      chk("rr_2", rd_log[2], 25'h00C0300);
    end
    rd_log.delete();
    fork
      do_req(0, 18'h00104, 0);
      do_req(1, 18'h00204, 0);
    join
    chk("rr_wrap_cnt", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      chk("rr_wrap_0", rd_log[0], 25'h0040104);
      chk("rr_wrap_1", rd_log[1], 25'h0080204);
    end

    // inv while the read is outstanding: acked but not cached.
    rv_lo = 5; rv_hi = 5;
    n0 = n_rd;
    fork
      do_req(1, 18'h00208, 0);
      begin
        c = 0;
        while (n_rd == n0 && c < 100) begin @(negedge clk); c++; end
        pulse_inv();
      end
    join
    rv_lo = 0; rv_hi = 0;
    mh_vld[1] = 1'b0;
    do_req(1, 18'h00208, 0);
    chk("t5_remiss_rd", n_rd, n0 + 2);

    // Reset while waiting for read data; the late rvalid must be ignored.
    rv_hold = 1'b1;
    n0 = n_rd;
    @(posedge clk); #1;
    clt_ofs[18 +: 18] = 18'h00A00;
    clt_req[1] = 1'b1;
    c = 0;
    while (n_rd == n0 && c < 50) begin @(negedge clk); c++; end
    chk("t6_reached_wait", (n_rd != n0), 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_sdr_req", sdr_req, 1'b0);
    chk("t6_rst_ack", clt_ack, 3'b000);
    chk("t6_rst_addr", sdr_addr, 25'h0);
    clt_req[1] = 1'b0;
    for (int k = 0; k < 3; k++) mh_vld[k] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv_hold = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("t6_quiet_ack", clt_ack, 3'b000);
      chk("t6_quiet_req", sdr_req, 1'b0);
    end
    do_req(1, 18'h00A00, 4);
    chk("t6_after_addr", last_rd(), 25'h0080A00);

    // Randomized contention with random controller delays.
    ack_lo = 0; ack_hi = 3; rv_lo = 0; rv_hi = 3;
    for (int r = 0; r < 6; r++) begin
      fork
        client_loop(0);
        client_loop(1);
        client_loop(2);
      join
      if ($urandom_range(1, 0) == 1) pulse_inv();
    end

    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("sb_drain_c%0d", k), sbq[k].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
